// File: rtl/sm_1153_route_sequencer_pkg.sv
// Shared definitions for the route sequencer: command codes, FSM states and
// route-code legality.
package sm_1153_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_REV   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_TURN,
    ST_REV,
    ST_DONE
  } seq_state_e;

  // Only forward, left, right and reverse may be stored in a route.
  function automatic logic cmd_is_legal(input logic [2:0] code);
    return (code >= CMD_FWD) && (code <= CMD_REV);
  endfunction

endpackage

// File: rtl/sm_1153_route_sequencer_if.sv
// Route-load channel between the host/UART loader and the sequencer.
interface sm_1153_route_sequencer_if;

  logic       load_valid;
  logic [2:0] load_cmd;
  logic       load_ready;
  logic       load_err;

  modport master (
    output load_valid,
    output load_cmd,
    input  load_ready,
    input  load_err
  );

  modport slave (
    input  load_valid,
    input  load_cmd,
    output load_ready,
    output load_err
  );

endinterface

// File: rtl/sm_1153_route_mem.sv
// Route storage: append-only register array with clear and indexed
// combinational read. Entries persist across playbacks.
module sm_1153_route_mem
  import sm_1153_pkg::*;
#(
  parameter  int unsigned ROUTE_DEPTH = 16,
  localparam int unsigned IDX_W       = $clog2(ROUTE_DEPTH + 1),
  localparam int unsigned ADDR_W      = (ROUTE_DEPTH > 1) ? $clog2(ROUTE_DEPTH) : 1
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_data,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [2:0]       rd_data,
  output logic [IDX_W-1:0] count,
  output logic             full
);

  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(ROUTE_DEPTH);

  logic [2:0]       mem_q [ROUTE_DEPTH];
  logic [2:0]       mem_d [ROUTE_DEPTH];
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] count_d;

  // Append at the fill level; clear only drops the fill level.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en && !full) begin
      mem_d[count_q[ADDR_W-1:0]] = wr_data;
      count_d                    = count_q + IDX_W'(1);
    end
  end

  // Storage and fill-level registers.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROUTE_DEPTH; i++) begin
        mem_q[i] <= CMD_NONE;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  // Read beyond the array (index == depth) returns a harmless halt code.
  always_comb begin
    rd_data = CMD_NONE;
    if (rd_idx < DEPTH_C) begin
      rd_data = mem_q[rd_idx[ADDR_W-1:0]];
    end
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);

endmodule

// File: rtl/sm_1153_route_sequencer.sv
// Route sequencer: loads a list of turn decisions, then plays one per
// intersection pulse while driving the motor command bus.
module sm_1153_route_sequencer
  import sm_1153_pkg::*;
#(
  parameter  int unsigned ROUTE_DEPTH = 16,
  parameter  int unsigned TURN_CYCLES = 25_000_000,
  parameter  int unsigned REV_CYCLES  = 50_000_000,
  localparam int unsigned IDX_W       = $clog2(ROUTE_DEPTH + 1)
) (
  input  logic                      clk_50,
  input  logic                      rst_n,
  sm_1153_route_sequencer_if.slave  load_if,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      node_detect,
  output logic [2:0]                robo_command,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          step_idx
);

  localparam int unsigned MAX_CYC = (TURN_CYCLES > REV_CYCLES) ? TURN_CYCLES : REV_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES - 1);
  localparam logic [TMR_W-1:0] REV_LOAD  = TMR_W'(REV_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             load_ready;
  logic             mem_wr;
  logic             mem_clr;
  logic [2:0]       mem_rd_data;
  logic [IDX_W-1:0] count;
  logic             full;

  sm_1153_route_mem #(
    .ROUTE_DEPTH(ROUTE_DEPTH)
  ) u_route_mem (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .wr_en  (mem_wr),
    .wr_data(load_if.load_cmd),
    .clr    (mem_clr),
    .rd_idx (step_q),
    .rd_data(mem_rd_data),
    .count  (count),
    .full   (full)
  );

  // Load acceptance, next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    step_d     = step_q;
    tmr_d      = tmr_q;
    mem_wr     = 1'b0;
    mem_clr    = 1'b0;
    load_ready = (state_q == ST_IDLE) && !full && !start;

    if (load_if.load_valid && load_ready) begin
      if (cmd_is_legal(load_if.load_cmd)) begin
        mem_wr = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Abort outranks node pulses and timer expiry in every active state.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NONE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            mem_clr = 1'b1;
            step_d  = '0;
          end
          if (start) begin
            step_d = '0;
            if (count != '0) begin
              state_d = ST_FOLLOW;
              cmd_d   = CMD_FWD;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_DONE;
              cmd_d   = CMD_NONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_FOLLOW: begin
          if (node_detect) begin
            if (step_q < count) begin
              step_d = step_q + IDX_W'(1);
              if ((mem_rd_data == CMD_LEFT) || (mem_rd_data == CMD_RIGHT)) begin
                state_d = ST_TURN;
                cmd_d   = mem_rd_data;
                tmr_d   = TURN_LOAD;
              end else if (mem_rd_data == CMD_REV) begin
                state_d = ST_REV;
                cmd_d   = CMD_REV;
                tmr_d   = REV_LOAD;
              end
            end else begin
              state_d = ST_DONE;
              cmd_d   = CMD_NONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        ST_TURN, ST_REV: begin
          if (tmr_q == '0) begin
            state_d = ST_FOLLOW;
            cmd_d   = CMD_FWD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, hold timer, step index and registered outputs.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      tmr_q   <= tmr_d;
    end
  end

  assign load_if.load_ready = load_ready;
  assign load_if.load_err   = err_q;
  assign robo_command       = cmd_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign step_idx           = step_q;

endmodule

// File: tb/tb_sm_1153_route_sequencer.sv
// Self-checking bench for the route sequencer with a behavioural route model.
module tb_sm_1153_route_sequencer;

  localparam int DEPTH = 16;
  localparam int TC    = 4;
  localparam int RC    = 6;
  localparam int IW    = $clog2(DEPTH + 1);

  logic          clk_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          node_detect = 1'b0;
  logic [2:0]    robo_command;
  logic          busy;
  logic          done;
  logic [IW-1:0] step_idx;

  sm_1153_route_sequencer_if lif();

  sm_1153_route_sequencer #(
    .ROUTE_DEPTH(DEPTH),
    .TURN_CYCLES(TC),
    .REV_CYCLES (RC)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .load_if     (lif.slave),
    .clear       (clear),
    .start       (start),
    .abort       (abort),
    .node_detect (node_detect),
    .robo_command(robo_command),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  always #10 clk_50 = ~clk_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: route list, playing flag, remaining hold cycles.
  int route[$];
  bit m_active, m_done, m_err;
  int m_cmd, m_step, m_hold;

  task automatic model_reset();
    route.delete();
    m_active = 0; m_done = 0; m_err = 0;
    m_cmd = 0; m_step = 0; m_hold = 0;
  endtask

  function automatic bit model_ready();
    return !m_active && !m_done && (route.size() < DEPTH);
  endfunction

  task automatic model_edge(input bit nd, input bit ab, input bit st, input bit cl,
                            input bit lv, input int lc);
    int code;
    m_err = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (lv && !st && route.size() < DEPTH) begin
        if (lc >= 1 && lc <= 4) route.push_back(lc);
        else m_err = 1;
      end
      if (cl) begin
        route.delete();
        m_step = 0;
      end
      if (st) begin
        m_step = 0;
        m_hold = 0;
        if (route.size() > 0) begin
          m_active = 1; m_cmd = 1;
        end else begin
          m_done = 1; m_cmd = 0;
        end
      end
    end else if (ab) begin
      m_active = 0; m_cmd = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_cmd = 1;
    end else if (nd) begin
      if (m_step < route.size()) begin
        code = route[m_step];
        m_step++;
        if (code == 2 || code == 3) begin m_cmd = code; m_hold = TC; end
        else if (code == 4) begin m_cmd = 4; m_hold = RC; end
      end else begin
        m_active = 0; m_cmd = 0; m_done = 1;
      end
    end
  endtask

  task automatic tick(input bit nd, input bit ab, input bit st, input bit cl);
    node_detect = nd; abort = ab; start = st; clear = cl;
    @(posedge clk_50);
    model_edge(nd, ab, st, cl, 1'b0, 0);
    #1;
    node_detect = 0; abort = 0; start = 0; clear = 0;
  endtask

  task automatic offer(input logic [2:0] code, output bit rdy);
    lif.load_valid = 1'b1;
    lif.load_cmd   = code;
    #1 rdy = lif.load_ready;
    @(posedge clk_50);
    model_edge(0, 0, 0, 0, 1'b1, int'(code));
    #1 lif.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (robo_command !== 3'd0) begin n_bad++; $display("FAIL reset_cmd got %0d want 0", robo_command); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (step_idx !== '0) begin n_bad++; $display("FAIL reset_step got %0d want 0", step_idx); end
    n_cmp++; if (lif.load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", lif.load_err); end
    n_cmp++; if (lif.load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", lif.load_ready); end
  endtask

  task automatic test_illegal_codes();
    logic [2:0] bad_codes [3];
    bit rdy;
    bad_codes[0] = 3'd0; bad_codes[1] = 3'd5; bad_codes[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      offer(bad_codes[i], rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL ill_ready code %0d got %b want 1", bad_codes[i], rdy); end
      n_cmp++; if (lif.load_err !== 1'b1) begin n_bad++; $display("FAIL ill_err code %0d got %b want 1", bad_codes[i], lif.load_err); end
    end
    tick(0, 0, 1, 0);
    n_cmp++; if (lif.load_err !== 1'b0) begin n_bad++; $display("FAIL ill_err_clear got %b want 0", lif.load_err); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done got %b want 1", done); end
    n_cmp++; if (robo_command !== 3'd0) begin n_bad++; $display("FAIL empty_cmd got %0d want 0", robo_command); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy got %b want 0", busy); end
    tick(0, 0, 0, 0);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done_drop got %b want 0", done); end
  endtask

  task automatic test_directed_route();
    int codes[4] = '{2, 1, 3, 4};
    int want[8] = '{1, 2, 1, 3, 1, 4, 1, 0};
    int trace[$];
    int n2, n3, n4, done_cnt, cyc;
    bit rdy;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      offer(3'(codes[i]), rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL dir_ready entry %0d got %b want 1", i, rdy); end
    end
    tick(0, 0, 1, 0);
    n_cmp++; if (robo_command !== 3'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL dir_start got cmd %0d busy %b want 1 1", robo_command, busy); end
    trace.push_back(int'(robo_command));
    n2 = 0; n3 = 0; n4 = 0; done_cnt = 0; cyc = 0;
    while ((m_active || m_done) && cyc < 200) begin
      tick(cyc % 3 == 0, 0, 0, 0);
      cyc++;
      n_cmp++; if (robo_command !== 3'(m_cmd)) begin n_bad++; $display("FAIL dir_cmd cyc %0d got %0d want %0d", cyc, robo_command, m_cmd); end
      n_cmp++; if (step_idx !== IW'(m_step)) begin n_bad++; $display("FAIL dir_step cyc %0d got %0d want %0d", cyc, step_idx, m_step); end
      n_cmp++; if (busy !== m_active || done !== m_done) begin n_bad++; $display("FAIL dir_flags cyc %0d got busy %b done %b want %b %b", cyc, busy, done, m_active, m_done); end
      if (int'(robo_command) != trace[$]) trace.push_back(int'(robo_command));
      if (robo_command == 3'd2) n2++;
      if (robo_command == 3'd3) n3++;
      if (robo_command == 3'd4) n4++;
      if (done === 1'b1) done_cnt++;
    end
    n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL dir_timeout got %0d cycles want < 200", cyc); end
    n_cmp++; if (trace.size() != 8) begin n_bad++; $display("FAIL dir_trace_len got %0d want 8", trace.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_cmp++; if (trace[i] != want[i]) begin n_bad++; $display("FAIL dir_trace[%0d] got %0d want %0d", i, trace[i], want[i]); end
    end
    n_cmp++; if (n2 != TC || n3 != TC || n4 != RC) begin n_bad++; $display("FAIL dir_hold got %0d/%0d/%0d want %0d/%0d/%0d", n2, n3, n4, TC, TC, RC); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL dir_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (step_idx !== IW'(4)) begin n_bad++; $display("FAIL dir_final_step got %0d want 4", step_idx); end
  endtask

  task automatic test_full();
    bit rdy;
    int cyc;
    tick(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      offer(3'($urandom_range(1, 4)), rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready entry %0d got %b want 1", i, rdy); end
    end
    offer(3'd1, rdy);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL full_17th_ready got %b want 0", rdy); end
    n_cmp++; if (lif.load_err !== 1'b0) begin n_bad++; $display("FAIL full_17th_err got %b want 0", lif.load_err); end
    tick(0, 0, 1, 0);
    offer(3'd2, rdy);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL follow_ready got %b want 0", rdy); end
    cyc = 0;
    while ((m_active || m_done) && cyc < 400) begin
      tick(cyc % 2 == 0, 0, 0, 0);
      cyc++;
      n_cmp++; if (robo_command !== 3'(m_cmd) || step_idx !== IW'(m_step)) begin n_bad++; $display("FAIL full_play cyc %0d got cmd %0d step %0d want %0d %0d", cyc, robo_command, step_idx, m_cmd, m_step); end
    end
    n_cmp++; if (cyc >= 400) begin n_bad++; $display("FAIL full_timeout got %0d cycles want < 400", cyc); end
    n_cmp++; if (step_idx !== IW'(DEPTH)) begin n_bad++; $display("FAIL full_final_step got %0d want %0d", step_idx, DEPTH); end
  endtask

  task automatic test_abort_and_ignore();
    bit rdy;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    offer(3'd2, rdy);
    offer(3'd3, rdy);
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    n_cmp++; if (robo_command !== 3'd2 || step_idx !== IW'(1)) begin n_bad++; $display("FAIL turn_enter got cmd %0d step %0d want 2 1", robo_command, step_idx); end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    n_cmp++; if (step_idx !== IW'(m_step) || m_step != 1) begin n_bad++; $display("FAIL turn_node_ignored got step %0d want 1", step_idx); end
    n_cmp++; if (robo_command !== 3'd2) begin n_bad++; $display("FAIL turn_hold got cmd %0d want 2", robo_command); end
    tick(0, 1, 0, 0);
    n_cmp++; if (robo_command !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_out got cmd %0d busy %b done %b want 0 0 0", robo_command, busy, done); end
    n_cmp++; if (step_idx !== IW'(1)) begin n_bad++; $display("FAIL abort_step got %0d want 1", step_idx); end
    tick(0, 0, 1, 0);
    n_cmp++; if (robo_command !== 3'd1 || step_idx !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart got cmd %0d step %0d busy %b want 1 0 1", robo_command, step_idx, busy); end
    tick(1, 0, 0, 0);
    n_cmp++; if (robo_command !== 3'(m_cmd) || m_cmd != 2) begin n_bad++; $display("FAIL replay_first got cmd %0d want 2", robo_command); end
    tick(0, 1, 0, 0);
  endtask

  task automatic test_random();
    bit rdy, exp_rdy;
    int len, cyc;
    for (int it = 0; it < 8; it++) begin
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      len = $urandom_range(0, 8);
      for (int k = 0; k < len; k++) begin
        exp_rdy = model_ready();
        offer(3'($urandom_range(0, 7)), rdy);
        n_cmp++; if (rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready it %0d got %b want %b", it, rdy, exp_rdy); end
        n_cmp++; if (lif.load_err !== m_err) begin n_bad++; $display("FAIL rnd_err it %0d got %b want %b", it, lif.load_err, m_err); end
      end
      tick(0, 0, 1, 0);
      cyc = 0;
      while ((m_active || m_done) && cyc < 400) begin
        tick($urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0, 0, 0);
        cyc++;
        n_cmp++; if (robo_command !== 3'(m_cmd) || busy !== m_active || done !== m_done || step_idx !== IW'(m_step))
        begin
          n_bad++;
          $display("FAIL rnd_play it %0d cyc %0d got cmd %0d busy %b done %b step %0d want %0d %b %b %0d",
                   it, cyc, robo_command, busy, done, step_idx, m_cmd, m_active, m_done, m_step);
        end
      end
      if (cyc >= 400) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_timeout it %0d got %0d cycles want < 400", it, cyc);
        tick(0, 1, 0, 0);
      end
    end
  endtask

  task automatic test_reset_mid_rev();
    bit rdy;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    offer(3'd4, rdy);
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    n_cmp++; if (robo_command !== 3'd4) begin n_bad++; $display("FAIL rev_active got cmd %0d want 4", robo_command); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (robo_command !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_async got cmd %0d busy %b done %b want 0 0 0", robo_command, busy, done); end
    n_cmp++; if (step_idx !== '0 || lif.load_err !== 1'b0) begin n_bad++; $display("FAIL rst_async_step got step %0d err %b want 0 0", step_idx, lif.load_err); end
    #4 rst_n = 1'b1;
    @(posedge clk_50); #1;
    n_cmp++; if (lif.load_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", lif.load_ready); end
    tick(0, 0, 1, 0);
    n_cmp++; if (done !== 1'b1 || robo_command !== 3'd0) begin n_bad++; $display("FAIL rst_route_lost got done %b cmd %0d want 1 0", done, robo_command); end
    tick(0, 0, 0, 0);
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_cmd   = 3'd0;
    model_reset();
    repeat (3) @(posedge clk_50);
    #5 rst_n = 1'b1;
    @(posedge clk_50); #1;
    test_reset();
    test_illegal_codes();
    test_directed_route();
    test_full();
    test_abort_and_ignore();
    test_random();
    test_reset_mid_rev();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim time exceeded got %0t want < 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
